control_unit: RTL

- Hardwired Moore control FSM sitting directly upstream of the processor datapath.
- Fetches an instruction, then decodes the IR value the datapath feeds back.
- For each T-step it drives the bus-source selects, register-load strobes, ALU opcode, memory read/write and the Gra/Grb/Grc/Rin/Rout/BAout lines consumed by the select-and-encode logic.
- Sequences fetch (T0-T2) and execute (T3-T7) for the full 27-instruction set.

---
 rtl/cpu_pkg.sv | 78 +++++++
 rtl/control_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, ALU operation
// codes, FSM state encoding and small decode helpers.
package cpu_pkg;

    // Instruction opcodes (ir[31:27]), ascending
    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ROR  = 5'd9;
    localparam logic [4:0] OP_ROL  = 5'd10;
    localparam logic [4:0] OP_ADDI = 5'd11;
    localparam logic [4:0] OP_ANDI = 5'd12;
    localparam logic [4:0] OP_ORI  = 5'd13;
    localparam logic [4:0] OP_MUL  = 5'd14;
    localparam logic [4:0] OP_DIV  = 5'd15;
    localparam logic [4:0] OP_NEG  = 5'd16;
    localparam logic [4:0] OP_NOT  = 5'd17;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_JR   = 5'd19;
    localparam logic [4:0] OP_JAL  = 5'd20;
    localparam logic [4:0] OP_IN   = 5'd21;
    localparam logic [4:0] OP_OUT  = 5'd22;
    localparam logic [4:0] OP_MFHI = 5'd23;
    localparam logic [4:0] OP_MFLO = 5'd24;
    localparam logic [4:0] OP_NOP  = 5'd25;
    localparam logic [4:0] OP_HALT = 5'd26;

    // ALU operation codes share the encoding of the matching opcode
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    // Control FSM states
    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        T0       = 4'd1,
        T1       = 4'd2,
        T2       = 4'd3,
        T3       = 4'd4,
        T4       = 4'd5,
        T5       = 4'd6,
        T6       = 4'd7,
        T7       = 4'd8,
        HALT_ST  = 4'd9
    } state_t;

    // Final execute step of each instruction; undefined opcodes behave as nop
    function automatic state_t last_step(input logic [4:0] op);
        state_t s;
        case (op)
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI:    s = T5;
            OP_LD, OP_ST:                                s = T7;
            OP_MUL, OP_DIV, OP_BR:                       s = T6;
            OP_NEG, OP_NOT, OP_JAL:                      s = T4;
            default:                                     s = T3;
        endcase
        return s;
    endfunction

    // ALU operation for the immediate/address-offset add in T4
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ANDI: a = ALU_AND;
            OP_ORI:  a = ALU_OR;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control FSM: fetch in T0-T2, execute in T3-T7, then back to
// T0 (or HALT_ST). All control outputs decode combinationally from the
// current state, the IR opcode and the branch condition flop.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        In_Portout,
    output logic        LOout,
    output logic        HIout,
    output logic        MARIn,
    output logic        ZIn,
    output logic        PCIn,
    output logic        MDRIn,
    output logic        IRIn,
    output logic        YIn,
    output logic        IncPC,
    output logic        HiIn,
    output logic        LoIn,
    output logic        CONIn,
    output logic        OutPortIn,
    output logic        R15In,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        read,
    output logic        write,
    output logic [4:0]  alu_op,
    output logic        run,
    output state_t      dbg_state
);

    state_t     r_state;
    state_t     w_next_state;
    state_t     w_last;
    logic [7:0] r_hold;
    logic [4:0] w_opcode;
    logic       w_unused_ir;

    assign w_opcode    = ir[31:27];
    assign w_unused_ir = ^ir[26:0];
    assign w_last      = last_step(w_opcode);
    assign dbg_state   = r_state;

    // State register; clr forces RESET_ST immediately
    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= RESET_ST;
        else     r_state <= w_next_state;
    end

    // Counts cycles spent in RESET_ST after clr releases (saturating)
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                                      r_hold <= 8'd0;
        else if (r_state == RESET_ST && r_hold != 8'hFF) r_hold <= r_hold + 8'd1;
    end

    // Next-state: step through T-states, leave at the instruction's last step
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RESET_ST: begin
                if (32'(r_hold) + 32'd1 >= RESET_PC_HOLD) w_next_state = T0;
            end
            HALT_ST: w_next_state = HALT_ST;
            default: begin
                if (r_state == w_last) begin
                    if (w_opcode == OP_HALT || stop) w_next_state = HALT_ST;
                    else                            w_next_state = T0;
                end else begin
                    w_next_state = state_t'(r_state + 4'd1);
                end
            end
        endcase
    end

    // Output decode: every strobe defaults low, then the active step raises its set
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        Cout = 1'b0; In_Portout = 1'b0; LOout = 1'b0; HIout = 1'b0;
        MARIn = 1'b0; ZIn = 1'b0; PCIn = 1'b0; MDRIn = 1'b0; IRIn = 1'b0;
        YIn = 1'b0; IncPC = 1'b0; HiIn = 1'b0; LoIn = 1'b0; CONIn = 1'b0;
        OutPortIn = 1'b0; R15In = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        read = 1'b0; write = 1'b0; alu_op = 5'd0; run = 1'b0;
        case (r_state)
            T0: begin
                run = 1'b1; PCout = 1'b1; MARIn = 1'b1; IncPC = 1'b1; ZIn = 1'b1;
            end
            T1: begin
                run = 1'b1; Zlowout = 1'b1; PCIn = 1'b1; read = 1'b1; MDRIn = 1'b1;
            end
            T2: begin
                run = 1'b1; MDRout = 1'b1; IRIn = 1'b1;
            end
            T3: begin
                run = 1'b1;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR,
                    OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; Rout = 1'b1; YIn = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; YIn = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        Gra = 1'b1; Rout = 1'b1; YIn = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        Grb = 1'b1; Rout = 1'b1; alu_op = w_opcode; ZIn = 1'b1;
                    end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1; end
                    OP_JAL:  begin PCout = 1'b1; R15In = 1'b1; end
                    OP_IN:   begin In_Portout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                run = 1'b1;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                        Grc = 1'b1; Rout = 1'b1; alu_op = w_opcode; ZIn = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
                        Cout = 1'b1; alu_op = imm_alu_op(w_opcode); ZIn = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        Grb = 1'b1; Rout = 1'b1; alu_op = w_opcode; ZIn = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_BR:          begin PCout = 1'b1; YIn = 1'b1; end
                    OP_JAL:         begin Gra = 1'b1; Rout = 1'b1; PCIn = 1'b1; end
                    default: ;
                endcase
            end
            T5: begin
                run = 1'b1;
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR,
                    OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_LD, OP_ST:   begin Zlowout = 1'b1; MARIn = 1'b1; end
                    OP_MUL, OP_DIV: begin Zlowout = 1'b1; LoIn = 1'b1; end
                    OP_BR:          begin Cout = 1'b1; alu_op = ALU_ADD; ZIn = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                run = 1'b1;
                case (w_opcode)
                    OP_LD:          begin read = 1'b1; MDRIn = 1'b1; end
                    OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRIn = 1'b1; end
                    OP_MUL, OP_DIV: begin Zhighout = 1'b1; HiIn = 1'b1; end
                    OP_BR: begin
                        if (con_ff) begin Zlowout = 1'b1; PCIn = 1'b1; end
                    end
                    default: ;
                endcase
            end
            T7: begin
                run = 1'b1;
                case (w_opcode)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
